e203_ifu_pf_ifetch: RTL
=======================

Name: e203_ifu_pf_ifetch

Overview:
Parametrised instruction-fetch front end for the E203 IFU. It replaces the single-outstanding fetch with a prefetcher that issues sequential 32-bit fetches ahead of the decoder. Up to DEPTH fetches can be in flight or buffered at once. It sits between the IFU bus interface (ifu_req/ifu_rsp) and the EXU-facing instruction port (ifu_o), and handles pipeline flush and halt.

Parameters:
PC_W, 32, PC/address width (>=8)
DEPTH, 4, instruction buffer entries and maximum in-flight plus buffered fetches (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc_rtvec  in  PC_W  reset vector, sampled while rst_n=0
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  bus accepts request
ifu_req_pc  out  PC_W  fetch address, word aligned
ifu_rsp_valid  in  1  fetch response valid, in request order
ifu_rsp_ready  out  1  tied 1
ifu_rsp_err  in  1  bus error for this response
ifu_rsp_instr  in  32  fetched instruction
ifu_o_valid  out  1  instruction available to EXU
ifu_o_ready  in  1  EXU accepts
ifu_o_pc  out  PC_W  PC of ifu_o_ir
ifu_o_ir  out  32  instruction
ifu_o_err  out  1  fetch error flag for this instruction
pipe_flush_req  in  1  redirect request
pipe_flush_pc  in  PC_W  redirect target
pipe_flush_ack  out  1  tied 1 (flush accepted the same cycle)
ifu_halt_req  in  1  halt request
ifu_halt_ack  out  1  halted, bus idle

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc <= {pc_rtvec[PC_W-1:2],2'b00}.
  - Buffer empty; discard_cnt=0.
  - ifu_req_valid=0, ifu_o_valid=0, ifu_halt_ack=0.
  - First request is issued in the first cycle after rst_n deasserts.
- Buffer: ring of DEPTH entries {pc, ir, err, filled}, with head, fill and tail pointers (log2 DEPTH bits, wrapping).
  - Request handshake allocates at tail with pc=fetch_pc, filled=0.
  - Response fills the entry at the fill pointer.
  - ifu_o presents the head entry; it is valid only when filled.
- Occupancy: occ = allocated entries + discard_cnt.
- Request: ifu_req_valid = !ifu_halt_req && !pipe_flush_req && occ<DEPTH.
  - ifu_req_pc = fetch_pc.
  - On handshake, fetch_pc += 4, modulo 2^PC_W (wraps to 0).
- Response: accepted every cycle ifu_rsp_valid=1.
  - If discard_cnt>0: decrement discard_cnt and drop the response.
  - Else: fill the entry with instr and err, and advance the fill pointer.
  - A response with nothing outstanding is a protocol violation and is ignored.
- Output: handshake ifu_o_valid&&ifu_o_ready pops the head.
  - Pop, alloc and fill may all occur in one cycle, including at full and at empty.
  - Latency: a response filling into an empty buffer appears on ifu_o_valid the next cycle.
  - ifu_o_err is passed through; prefetch continues after an error.
- Flush (pipe_flush_req=1):
  - ifu_o_valid is forced 0 in that cycle; no pop and no request occur.
  - Next state: buffer cleared.
  - discard_cnt <= discard_cnt + allocated-unfilled entries, minus 1 if a response arrives this cycle.
  - fetch_pc <= {pipe_flush_pc[PC_W-1:2],2'b00}.
  - Back-to-back flushes: the last target wins, and discards accumulate.
- Halt:
  - While ifu_halt_req=1, no new requests are issued; buffered entries are still delivered.
  - ifu_halt_ack=1 (registered) once no entry is unfilled and discard_cnt=0.
  - ifu_halt_ack drops the cycle after ifu_halt_req drops.
  - A flush during halt updates fetch_pc and adds discards; ack waits for those discards to drain.

Test Plan:
- Reset with pc_rtvec=0x0000_1003, req_ready=1, rsp one cycle later, o_ready=1 -> req_pc sequence 0x1000,0x1004,0x1008...; o_pc in the same order, each ir equal to its response.
- o_ready=0, DEPTH=4, all responses returned -> exactly 4 requests, then req_valid=0. Raise o_ready for one cycle -> one pop, and the next request is at 0x1010.
- Flush to 0x2000 with 3 requests outstanding -> the next 3 responses are dropped, the first o_pc is 0x2000, and no stale ir appears.
- Response with err=1 for pc 0x1004 -> o_err=1 only for that entry; the 0x1008 fetch proceeds normally.
- Halt with 2 outstanding -> halt_ack=1 the cycle after the 2nd response, req_valid stays 0. Release -> ack=0 and fetch resumes at the next sequential pc.
- pc_rtvec=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Assert rst_n=0 mid-stream -> o_valid and req_valid are 0 immediately, and fetch restarts at the vector.

Source files
------------

// File: rtl/e203_ifu_pf_ifetch.sv
// Prefetching instruction-fetch front end for the E203 IFU: issues sequential word fetches
// ahead of the decoder into a DEPTH-entry ring and drops responses made stale by a flush.
module e203_ifu_pf_ifetch #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_rtvec,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [PC_W-1:0] ifu_req_pc,
  input  logic            ifu_rsp_valid,
  output logic            ifu_rsp_ready,
  input  logic            ifu_rsp_err,
  input  logic [31:0]     ifu_rsp_instr,
  output logic            ifu_o_valid,
  input  logic            ifu_o_ready,
  output logic [PC_W-1:0] ifu_o_pc,
  output logic [31:0]     ifu_o_ir,
  output logic            ifu_o_err,
  input  logic            pipe_flush_req,
  input  logic [PC_W-1:0] pipe_flush_pc,
  output logic            pipe_flush_ack,
  input  logic            ifu_halt_req,
  output logic            ifu_halt_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [PC_W-1:0] r_fetchPc;
  ptr_t            r_head;
  ptr_t            r_fill;
  ptr_t            r_tail;
  cnt_t            r_allocCnt;
  cnt_t            r_unfilledCnt;
  cnt_t            r_discardCnt;
  logic            r_haltAck;
  logic [DEPTH-1:0] r_filled;
  logic [PC_W-1:0] r_pc [DEPTH];
  logic [31:0]     r_ir [DEPTH];
  logic            r_err [DEPTH];

  logic [CW:0] w_occ;
  logic        w_reqValid;
  logic        w_reqHs;
  logic        w_rspDrop;
  logic        w_rspFill;
  logic        w_oValid;
  logic        w_pop;
  cnt_t        w_allocNext;
  cnt_t        w_unfilledNext;
  cnt_t        w_discardNext;
  logic        w_unused;

  assign w_unused = ^{pc_rtvec[1:0], pipe_flush_pc[1:0]};

  assign w_occ      = {1'b0, r_allocCnt} + {1'b0, r_discardCnt};
  assign w_reqValid = rst_n && !ifu_halt_req && !pipe_flush_req && (w_occ < LP_DEPTH);
  assign w_reqHs    = w_reqValid && ifu_req_ready;
  assign w_rspDrop  = ifu_rsp_valid && (r_discardCnt != '0);
  assign w_rspFill  = ifu_rsp_valid && (r_discardCnt == '0) && (r_unfilledCnt != '0);
  assign w_oValid   = !pipe_flush_req && (r_allocCnt != '0) && r_filled[r_head];
  assign w_pop      = w_oValid && ifu_o_ready;

  // A flush empties the ring; every fetch still on the bus becomes a response to drop.
  always_comb begin
    w_allocNext    = r_allocCnt + cnt_t'(w_reqHs) - cnt_t'(w_pop);
    w_unfilledNext = r_unfilledCnt + cnt_t'(w_reqHs) - cnt_t'(w_rspFill);
    w_discardNext  = r_discardCnt - cnt_t'(w_rspDrop);
    if (pipe_flush_req) begin
      w_allocNext    = '0;
      w_unfilledNext = '0;
      w_discardNext  = r_discardCnt + r_unfilledCnt
                       - cnt_t'(ifu_rsp_valid && ((r_discardCnt != '0) || (r_unfilledCnt != '0)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchPc     <= {pc_rtvec[PC_W-1:2], 2'b00};
      r_head        <= '0;
      r_fill        <= '0;
      r_tail        <= '0;
      r_allocCnt    <= '0;
      r_unfilledCnt <= '0;
      r_discardCnt  <= '0;
      r_haltAck     <= 1'b0;
      r_filled      <= '0;
    end else begin
      r_allocCnt    <= w_allocNext;
      r_unfilledCnt <= w_unfilledNext;
      r_discardCnt  <= w_discardNext;
      r_haltAck     <= ifu_halt_req && (w_unfilledNext == '0) && (w_discardNext == '0);
      if (pipe_flush_req) begin
        r_fetchPc <= {pipe_flush_pc[PC_W-1:2], 2'b00};
        r_head    <= '0;
        r_fill    <= '0;
        r_tail    <= '0;
        r_filled  <= '0;
      end else begin
        if (w_reqHs) begin
          r_tail           <= r_tail + ptr_t'(1);
          r_fetchPc        <= r_fetchPc + PC_W'(4);
          r_filled[r_tail] <= 1'b0;
        end
        if (w_rspFill) begin
          r_fill           <= r_fill + ptr_t'(1);
          r_filled[r_fill] <= 1'b1;
        end
        if (w_pop) begin
          r_head           <= r_head + ptr_t'(1);
          r_filled[r_head] <= 1'b0;
        end
      end
    end
  end

  // Entry payload needs no reset: the filled flags decide what is visible.
  always_ff @(posedge clk) begin
    if (w_reqHs) begin
      r_pc[r_tail] <= r_fetchPc;
    end
    if (w_rspFill && !pipe_flush_req) begin
      r_ir[r_fill]  <= ifu_rsp_instr;
      r_err[r_fill] <= ifu_rsp_err;
    end
  end

  assign ifu_req_valid  = w_reqValid;
  assign ifu_req_pc     = r_fetchPc;
  assign ifu_rsp_ready  = 1'b1;
  assign ifu_o_valid    = w_oValid;
  assign ifu_o_pc       = r_pc[r_head];
  assign ifu_o_ir       = r_ir[r_head];
  assign ifu_o_err      = r_err[r_head];
  assign pipe_flush_ack = 1'b1;
  assign ifu_halt_ack   = r_haltAck;

endmodule
